// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_pkg
// Brief    : Shared DMA types: streamer request/response, error record, and
//            read-side queue/tracker entries.
// Revision : 1.0
// ============================================================================
package dma_pkg;

    localparam int DMA_ADDR_WIDTH = 32;
    localparam int DMA_DATA_WIDTH = 512;
    localparam int DMA_STRB_WIDTH = DMA_DATA_WIDTH / 8;

    localparam logic [1:0] DMA_AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] DMA_AXI_RESP_OKAY  = 2'b00;

    typedef logic [DMA_ADDR_WIDTH-1:0] axi_addr_t;
    typedef logic [DMA_DATA_WIDTH-1:0] axi_data_t;
    typedef logic [DMA_STRB_WIDTH-1:0] axi_strb_t;

    typedef enum logic [2:0] {
        DMA_NO_ERR      = 3'd0,
        DMA_SRC_ERR     = 3'd1,
        DMA_DST_ERR     = 3'd2,
        DMA_RD_RESP_ERR = 3'd3,
        DMA_RLAST_ERR   = 3'd4
    } dma_err_src_e;

    typedef struct packed {
        axi_addr_t  addr;
        logic [7:0] alen;
        logic [2:0] size;
        axi_strb_t  strb;
        logic       valid;
    } s_dma_axi_req_t;

    typedef struct packed {
        logic       ready;
        logic [1:0] resp;
    } s_dma_axi_resp_t;

    typedef struct packed {
        logic         valid;
        dma_err_src_e src;
        axi_addr_t    addr;
    } s_dma_error_t;

    typedef struct packed {
        axi_addr_t  addr;
        logic [7:0] alen;
        axi_strb_t  strb;
    } s_dma_rd_trk_t;

    typedef struct packed {
        axi_addr_t  addr;
        logic [7:0] alen;
        logic [2:0] size;
        axi_strb_t  strb;
    } s_dma_rd_req_ent_t;

endpackage
`default_nettype wire

// File: rtl/dma_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dma_sync_fifo
// Brief    : Single-clock FIFO of an arbitrary type; pointers carry an extra
//            wrap bit so full and empty are distinguished without a counter.
// Revision : 1.0
// ============================================================================
module dma_sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) + 1 : 1;
    localparam logic [PW-1:0] c_wrap = PW'(1) << (PW - 1);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;
    logic          w_push;
    logic          w_pop;
    T              r_mem [DEPTH];

    generate
        if (DEPTH > 1) begin : g_multi
            assign w_wr_idx = r_wr_ptr[IW-1:0];
            assign w_rd_idx = r_rd_ptr[IW-1:0];
        end else begin : g_single
            assign w_wr_idx = '0;
            assign w_rd_idx = '0;
        end
    endgenerate

    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = ((r_wr_ptr ^ r_rd_ptr) == c_wrap);
    assign dout   = r_mem[w_rd_idx];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_wr_idx] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/dma_rd_burst_issuer.sv
`default_nettype none
// ============================================================================
// Module   : dma_rd_burst_issuer
// Brief    : Queues streamer read requests, issues AXI4 AR bursts with bounded
//            outstanding count, and forwards R beats with strobes and checks.
// Revision : 1.0
// ============================================================================
module dma_rd_burst_issuer
    import dma_pkg::*;
#(
    parameter int REQ_FIFO_DEPTH  = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  s_dma_axi_req_t  dma_axi_req_i,
    output s_dma_axi_resp_t dma_axi_resp_o,
    output logic            arvalid_o,
    output logic [31:0]     araddr_o,
    output logic [7:0]      arlen_o,
    output logic [2:0]      arsize_o,
    output logic [1:0]      arburst_o,
    input  logic            arready_i,
    input  logic            rvalid_i,
    input  axi_data_t       rdata_i,
    input  logic [1:0]      rresp_i,
    input  logic            rlast_i,
    output logic            rready_o,
    output logic            rd_valid_o,
    output axi_data_t       rd_data_o,
    output axi_strb_t       rd_strb_o,
    output logic            rd_last_o,
    input  logic            rd_ready_i,
    input  logic            err_clr_i,
    output s_dma_error_t    rd_err_o,
    output logic            idle_o
);

    s_dma_rd_req_ent_t w_req_din;
    s_dma_rd_req_ent_t w_req_head;
    logic              w_req_push;
    logic              w_req_full;
    logic              w_req_empty;

    s_dma_rd_trk_t     w_trk_din;
    s_dma_rd_trk_t     w_trk_head;
    logic              w_trk_pop;
    logic              w_trk_full;
    logic              w_trk_empty;

    logic              r_ar_valid;
    axi_addr_t         r_ar_addr;
    logic [7:0]        r_ar_len;
    logic [2:0]        r_ar_size;
    logic              w_ar_hs;
    logic              w_load;

    logic [7:0]        r_beat_cnt;
    logic              w_beat;
    logic              w_exp_last;
    logic              w_resp_err;
    logic              w_rlast_err;
    s_dma_error_t      r_err;

    // ---------------------------------------------------------------- request queue
    assign w_req_push = dma_axi_req_i.valid & ~w_req_full;
    assign w_req_din  = '{addr: dma_axi_req_i.addr, alen: dma_axi_req_i.alen,
                          size: dma_axi_req_i.size, strb: dma_axi_req_i.strb};

    always_comb begin
        dma_axi_resp_o       = '0;
        dma_axi_resp_o.ready = ~w_req_full;
    end

    dma_sync_fifo #(
        .T     (s_dma_rd_req_ent_t),
        .DEPTH (REQ_FIFO_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_req_push),
        .din   (w_req_din),
        .pop   (w_load),
        .dout  (w_req_head),
        .full  (w_req_full),
        .empty (w_req_empty)
    );

    // ---------------------------------------------------------------- AR slot
    // The tracker entry is reserved at load time, so the slot never holds a
    // burst the tracker cannot accept.
    assign w_ar_hs = r_ar_valid & arready_i;
    assign w_load  = ~w_req_empty & ~w_trk_full & (~r_ar_valid | w_ar_hs);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ar_valid <= 1'b0;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
            r_ar_size  <= '0;
        end else if (w_load) begin
            r_ar_valid <= 1'b1;
            r_ar_addr  <= w_req_head.addr;
            r_ar_len   <= w_req_head.alen;
            r_ar_size  <= w_req_head.size;
        end else if (w_ar_hs) begin
            r_ar_valid <= 1'b0;
        end
    end

    assign arvalid_o = r_ar_valid;
    assign araddr_o  = r_ar_addr;
    assign arlen_o   = r_ar_len;
    assign arsize_o  = r_ar_size;
    assign arburst_o = r_ar_valid ? DMA_AXI_BURST_INCR : 2'b00;

    // ---------------------------------------------------------------- outstanding tracker
    assign w_trk_din = '{addr: w_req_head.addr, alen: w_req_head.alen, strb: w_req_head.strb};

    dma_sync_fifo #(
        .T     (s_dma_rd_trk_t),
        .DEPTH (MAX_OUTSTANDING)
    ) u_trk_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_load),
        .din   (w_trk_din),
        .pop   (w_trk_pop),
        .dout  (w_trk_head),
        .full  (w_trk_full),
        .empty (w_trk_empty)
    );

    // ---------------------------------------------------------------- R path
    assign rready_o   = rd_ready_i & ~w_trk_empty;
    assign rd_valid_o = rvalid_i & ~w_trk_empty;
    assign rd_data_o  = rdata_i;
    assign w_beat     = rvalid_i & rready_o;
    assign w_exp_last = (r_beat_cnt == w_trk_head.alen);
    assign rd_last_o  = rd_valid_o & w_exp_last;
    assign w_trk_pop  = w_beat & w_exp_last;

    // Only single-beat bursts carry a partial strobe; longer ones are full width.
    always_comb begin
        rd_strb_o = '0;
        if (rd_valid_o) begin
            if (w_trk_head.alen == 8'd0) rd_strb_o = w_trk_head.strb;
            else                         rd_strb_o = '1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_beat_cnt <= '0;
        end else if (w_beat) begin
            r_beat_cnt <= w_exp_last ? 8'd0 : r_beat_cnt + 8'd1;
        end
    end

    // ---------------------------------------------------------------- error capture
    assign w_resp_err  = w_beat & (rresp_i != DMA_AXI_RESP_OKAY);
    assign w_rlast_err = w_beat & (rlast_i != w_exp_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= '0;
        end else if ((w_resp_err | w_rlast_err) & (~r_err.valid | err_clr_i)) begin
            r_err.valid <= 1'b1;
            r_err.src   <= w_resp_err ? DMA_RD_RESP_ERR : DMA_RLAST_ERR;
            r_err.addr  <= w_trk_head.addr;
        end else if (err_clr_i) begin
            r_err <= '0;
        end
    end

    assign rd_err_o = r_err;
    assign idle_o   = w_req_empty & ~r_ar_valid & w_trk_empty;

endmodule
`default_nettype wire

// File: tb/tb_dma_rd_burst_issuer.sv
`default_nettype none
// Testbench for dma_rd_burst_issuer: scoreboard queues for AR and R beats,
// one task per scenario.
module tb_dma_rd_burst_issuer;
    import dma_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ar_exp_t;

    typedef struct packed {
        axi_data_t data;
        axi_strb_t strb;
        logic      last;
    } beat_exp_t;

    logic            clk = 1'b0;
    logic            rstn;
    s_dma_axi_req_t  req;
    s_dma_axi_resp_t resp;
    logic            arvalid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arready;
    logic            rvalid;
    axi_data_t       rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rready;
    logic            rd_valid;
    axi_data_t       rd_data;
    axi_strb_t       rd_strb;
    logic            rd_last;
    logic            rd_ready;
    logic            err_clr;
    s_dma_error_t    rd_err;
    logic            idle;

    int        total = 0;
    int        bad = 0;
    int        ar_hs_cnt = 0;
    ar_exp_t   ar_q[$];
    beat_exp_t beat_q[$];
    ar_exp_t   mon_ar;
    beat_exp_t mon_beat;

    dma_rd_burst_issuer #(
        .REQ_FIFO_DEPTH  (4),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .dma_axi_req_i  (req),
        .dma_axi_resp_o (resp),
        .arvalid_o      (arvalid),
        .araddr_o       (araddr),
        .arlen_o        (arlen),
        .arsize_o       (arsize),
        .arburst_o      (arburst),
        .arready_i      (arready),
        .rvalid_i       (rvalid),
        .rdata_i        (rdata),
        .rresp_i        (rresp),
        .rlast_i        (rlast),
        .rready_o       (rready),
        .rd_valid_o     (rd_valid),
        .rd_data_o      (rd_data),
        .rd_strb_o      (rd_strb),
        .rd_last_o      (rd_last),
        .rd_ready_i     (rd_ready),
        .err_clr_i      (err_clr),
        .rd_err_o       (rd_err),
        .idle_o         (idle)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    // Scoreboard: AR handshakes and delivered beats are popped and compared here.
    always @(negedge clk) begin
        if (rstn) begin
            if (arvalid && arready) begin
                ar_hs_cnt++;
                total++;
                if (ar_q.size() == 0) begin
                    bad++;
                    $display("FAIL ar_unexpected: got addr=%h, required no AR", araddr);
                end else begin
                    mon_ar = ar_q.pop_front();
                    if ({araddr, arlen, arsize, arburst} !== {mon_ar.addr, mon_ar.len, mon_ar.size, 2'b01}) begin
                        bad++;
                        $display("FAIL ar_fields: got addr=%h len=%0d size=%0d burst=%0d, required addr=%h len=%0d size=%0d burst=1",
                                 araddr, arlen, arsize, arburst, mon_ar.addr, mon_ar.len, mon_ar.size);
                    end
                end
            end
            if (rd_valid && rd_ready) begin
                total++;
                if (beat_q.size() == 0) begin
                    bad++;
                    $display("FAIL beat_unexpected: got rd_valid=1, required no beat");
                end else begin
                    mon_beat = beat_q.pop_front();
                    if (rd_data !== mon_beat.data) begin
                        bad++;
                        $display("FAIL beat_data: got %h, required %h", rd_data, mon_beat.data);
                    end
                    total++;
                    if (rd_strb !== mon_beat.strb) begin
                        bad++;
                        $display("FAIL beat_strb: got %h, required %h", rd_strb, mon_beat.strb);
                    end
                    total++;
                    if (rd_last !== mon_beat.last) begin
                        bad++;
                        $display("FAIL beat_last: got %b, required %b", rd_last, mon_beat.last);
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- stimulus helpers
    task automatic send_req(input logic [31:0] a, input logic [7:0] l, input axi_strb_t s);
        logic ok;
        req.addr = a; req.alen = l; req.size = 3'd6; req.strb = s; req.valid = 1'b1;
        ar_q.push_back('{addr: a, len: l, size: 3'd6});
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk); ok = resp.ready;
            @(posedge clk); #1;
        end
        req.valid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL req_accept: got ready=0 for 20 cycles, required handshake");
        end
    endtask

    task automatic r_burst(input logic [7:0] l, input axi_strb_t s, input int early_idx,
                           input int nolast, input int resp_idx);
        logic ok;
        beat_exp_t e;
        for (int i = 0; i <= int'(l); i++) begin
            for (int k = 0; k < DMA_DATA_WIDTH / 32; k++) rdata[k*32 +: 32] = $urandom();
            rvalid = 1'b1;
            rresp  = (i == resp_idx) ? 2'b10 : 2'b00;
            rlast  = (i == int'(l)) ? (nolast == 0) : (i == early_idx);
            e.data = rdata;
            e.strb = (l == 8'd0) ? s : {DMA_STRB_WIDTH{1'b1}};
            e.last = (i == int'(l));
            beat_q.push_back(e);
            ok = 1'b0;
            for (int c = 0; c < 20 && !ok; c++) begin
                @(negedge clk); ok = rready;
                @(posedge clk); #1;
            end
            if (!ok) begin
                total++; bad++;
                $display("FAIL r_accept: got rready=0 for 20 cycles, required beat %0d taken", i);
                beat_q.delete();
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                return;
            end
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    // ---------------------------------------------------------------- scenarios
    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        rvalid = 1'b1;
        @(negedge clk);
        total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid: got %b, required 0", arvalid); end
        total++; if (resp.ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b, required 1", resp.ready); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b, required 1", idle); end
        total++; if (rready !== 1'b0) begin bad++; $display("FAIL rst_rready: got %b, required 0", rready); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid: got %b, required 0", rd_valid); end
        total++; if (rd_err !== '0) begin bad++; $display("FAIL rst_err: got %h, required 0", rd_err); end
        total++; if ({arburst, arlen, rd_last} !== 11'd0) begin bad++; $display("FAIL rst_misc: got burst=%0d len=%0d last=%b, required 0", arburst, arlen, rd_last); end
        @(posedge clk); #1 rvalid = 1'b0;
    endtask

    task automatic test_single();
        arready = 1'b1;
        send_req(32'h1000, 8'd3, {DMA_STRB_WIDTH{1'b1}});
        @(negedge clk);
        total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL single_lat_n1: got arvalid=%b, required 0", arvalid); end
        @(negedge clk);
        total++; if (arvalid !== 1'b1) begin bad++; $display("FAIL single_lat_n2: got arvalid=%b, required 1", arvalid); end
        @(posedge clk); #1;
        r_burst(8'd3, '0, -1, 0, -1);
        repeat (2) @(posedge clk); #1;
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle: got %b, required 1", idle); end
        total++; if (ar_q.size() + beat_q.size() != 0) begin bad++; $display("FAIL single_drain: got %0d pending, required 0", ar_q.size() + beat_q.size()); end
    endtask

    task automatic test_narrow();
        axi_strb_t s;
        s = 64'h0000_00FF_0000_0000;
        send_req(32'h2040, 8'd0, s);
        r_burst(8'd0, s, -1, 0, -1);
        repeat (2) @(posedge clk); #1;
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL narrow_idle: got %b, required 1", idle); end
    endtask

    task automatic test_backpressure();
        axi_strb_t s [6];
        int        start;
        logic      take;
        logic      accepted;
        for (int k = 0; k < 6; k++) s[k] = axi_strb_t'(64'hF) << (k * 8);
        arready = 1'b0;
        for (int k = 0; k < 5; k++) send_req(32'h5000 + 32'(k * 64), 8'd0, s[k]);
        @(negedge clk);
        total++; if (resp.ready !== 1'b0) begin bad++; $display("FAIL bp_full: got ready=%b, required 0", resp.ready); end
        total++; if (arvalid !== 1'b1) begin bad++; $display("FAIL bp_slot: got arvalid=%b, required 1", arvalid); end
        @(posedge clk); #1;
        req.addr = 32'h5000 + 32'd320; req.alen = 8'd0; req.size = 3'd6; req.strb = s[5]; req.valid = 1'b1;
        ar_q.push_back('{addr: 32'h5000 + 32'd320, len: 8'd0, size: 3'd6});
        arready = 1'b1;
        start = ar_hs_cnt;
        accepted = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); take = req.valid && resp.ready;
            @(posedge clk); #1;
            if (take) begin req.valid = 1'b0; accepted = 1'b1; end
        end
        total++; if (ar_hs_cnt - start != 4) begin bad++; $display("FAIL bp_ar_count: got %0d, required 4", ar_hs_cnt - start); end
        total++; if (accepted !== 1'b1) begin bad++; $display("FAIL bp_sixth: got accepted=%b, required 1", accepted); end
        @(negedge clk);
        total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL bp_held: got arvalid=%b, required 0", arvalid); end
        @(posedge clk); #1;
        r_burst(8'd0, s[0], -1, 0, -1);
        start = ar_hs_cnt;
        repeat (3) @(posedge clk); #1;
        total++; if (ar_hs_cnt - start != 1) begin bad++; $display("FAIL bp_release: got %0d ARs, required 1", ar_hs_cnt - start); end
        for (int k = 1; k < 6; k++) r_burst(8'd0, s[k], -1, 0, -1);
        repeat (3) @(posedge clk); #1;
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL bp_idle: got %b, required 1", idle); end
        total++; if (ar_q.size() + beat_q.size() != 0) begin bad++; $display("FAIL bp_drain: got %0d pending, required 0", ar_q.size() + beat_q.size()); end
    endtask

    task automatic test_rlast_err();
        s_dma_error_t e;
        pulse_clr();
        send_req(32'h3000, 8'd1, {DMA_STRB_WIDTH{1'b1}});
        r_burst(8'd1, '0, 0, 0, -1);
        @(negedge clk);
        e.valid = 1'b1; e.src = DMA_RLAST_ERR; e.addr = 32'h3000;
        total++; if (rd_err !== e) begin bad++; $display("FAIL rlast_early: got %h, required %h", rd_err, e); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL rlast_ended: got idle=%b, required 1", idle); end
        @(posedge clk); #1;
        pulse_clr();
        send_req(32'h3100, 8'd0, 64'h00FF);
        r_burst(8'd0, 64'h00FF, -1, 1, -1);
        @(negedge clk);
        e.addr = 32'h3100;
        total++; if (rd_err !== e) begin bad++; $display("FAIL rlast_missing: got %h, required %h", rd_err, e); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL rlast_missing_end: got idle=%b, required 1", idle); end
        @(posedge clk); #1;
    endtask

    task automatic test_resp_err();
        s_dma_error_t e;
        pulse_clr();
        send_req(32'h4000, 8'd1, {DMA_STRB_WIDTH{1'b1}});
        r_burst(8'd1, '0, -1, 0, 0);
        @(negedge clk);
        e.valid = 1'b1; e.src = DMA_RD_RESP_ERR; e.addr = 32'h4000;
        total++; if (rd_err !== e) begin bad++; $display("FAIL resp_capture: got %h, required %h", rd_err, e); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (rd_err !== e) begin bad++; $display("FAIL resp_hold: got %h, required %h", rd_err, e); end
        @(posedge clk); #1;
        pulse_clr();
        @(negedge clk);
        total++; if (rd_err !== '0) begin bad++; $display("FAIL resp_clear: got %h, required 0", rd_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int start;
        arready = 1'b1;
        send_req(32'h6000, 8'd0, 64'h1);
        r_burst(8'd0, 64'h1, -1, 0, 0);
        start = ar_hs_cnt;
        send_req(32'h6100, 8'd3, {DMA_STRB_WIDTH{1'b1}});
        send_req(32'h6200, 8'd3, {DMA_STRB_WIDTH{1'b1}});
        for (int c = 0; c < 20 && ar_hs_cnt < start + 2; c++) @(posedge clk);
        #1;
        total++; if (ar_hs_cnt < start + 2) begin bad++; $display("FAIL rstmid_ar: got %0d ARs, required 2", ar_hs_cnt - start); end
        @(negedge clk);
        total++; if (idle !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got idle=%b, required 0", idle); end
        total++; if (rd_err.valid !== 1'b1) begin bad++; $display("FAIL rstmid_err_pre: got %b, required 1", rd_err.valid); end
        #2;
        rdata = '0; rvalid = 1'b1; rstn = 1'b0;
        #1;
        total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL rstmid_arvalid: got %b, required 0", arvalid); end
        total++; if (resp.ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b, required 1", resp.ready); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL rstmid_idle: got %b, required 1", idle); end
        total++; if ({rd_valid, rready, rd_last} !== 3'b000) begin bad++; $display("FAIL rstmid_r: got valid=%b ready=%b last=%b, required 0", rd_valid, rready, rd_last); end
        total++; if (rd_strb !== '0) begin bad++; $display("FAIL rstmid_strb: got %h, required 0", rd_strb); end
        total++; if (rd_err !== '0) begin bad++; $display("FAIL rstmid_err: got %h, required 0", rd_err); end
        ar_q.delete();
        beat_q.delete();
        rvalid = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if ({idle, arvalid} !== 2'b10) begin bad++; $display("FAIL rstmid_after: got idle=%b arvalid=%b, required 1 0", idle, arvalid); end
    endtask

    initial begin
        rstn = 1'b0; req = '0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
        rresp = 2'b00; rlast = 1'b0; rd_ready = 1'b1; err_clr = 1'b0;
        test_reset();
        test_single();
        test_narrow();
        test_backpressure();
        test_rlast_err();
        test_resp_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dma_rd_burst_issuer.md
# dma_rd_burst_issuer

Consumer side of the DMA streamer request interface: accepts `s_dma_axi_req_t` burst requests from the read streamer, queues them, drives the AXI4 AR channel with bounded outstanding bursts, and returns R-channel beats to the DMA data buffer with per-beat strobes. It checks `rlast` placement and `rresp`, and reports the first error to the DMA FSM.

## Interface
- `REQ_FIFO_DEPTH`, 4: request queue entries (power of two, ≥2).
- `MAX_OUTSTANDING`, 4: bursts loaded into AR but not yet fully returned (power of two, ≥1).
- `clk` in 1: single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `dma_axi_req_i` in `s_dma_axi_req_t`: streamer request; `addr`, `alen`, `size`, `strb`, `valid`.
- `dma_axi_resp_o` out `s_dma_axi_resp_t`: `ready` = request queue not full; all other fields 0.
- `arvalid_o` out 1; `araddr_o` out 32; `arlen_o` out 8; `arsize_o` out 3; `arburst_o` out 2; `arready_i` in 1.
- `rvalid_i` in 1; `rdata_i` in `DMA_DATA_WIDTH`; `rresp_i` in 2; `rlast_i` in 1; `rready_o` out 1.
- `rd_valid_o` out 1; `rd_data_o` out `DMA_DATA_WIDTH`; `rd_strb_o` out `axi_strb_t`; `rd_last_o` out 1; `rd_ready_i` in 1.
- `err_clr_i` in 1: clears sticky error.
- `rd_err_o` out `s_dma_error_t`: sticky first error.
- `idle_o` out 1: queue empty, AR slot empty, no bursts outstanding.

## Operation
- Request accept: push `{addr, alen, size, strb}` when `dma_axi_req_i.valid && dma_axi_resp_o.ready`. `ready` is combinational `~full`; a request offered while full is held by the streamer.
- AR slot: one output register. It loads the queue head (pop) when the head exists, the tracker is not full, and the slot is empty or handshaking this cycle.
  - Each load pushes `{addr, alen, strb}` to the outstanding tracker FIFO (depth `MAX_OUTSTANDING`).
  - `arburst_o` = INCR (2'b01).
  - AR fields stay stable while `arvalid_o && ~arready_i`.
- R path: pure combinational pass-through, gated by the tracker.
  - `rready_o` = `rd_ready_i && ~trk_empty`.
  - `rd_valid_o` = `rvalid_i && ~trk_empty`.
  - `rd_data_o` = `rdata_i`.
  - A beat is taken when `rvalid_i && rready_o`.
- Beat counter `beat_cnt` (8 bits) counts accepted beats of the tracker head.
  - The expected last beat is `beat_cnt == head.alen`. On it: `rd_last_o`=1, pop tracker, clear `beat_cnt`.
  - Strobe: `head.alen==0` → `head.strb`; otherwise `'1`.
- Errors are captured only when no error is held (first wins). `valid`=1 and `addr` = `head.addr` in all cases.
  - `rresp_i != 2'b00` on an accepted beat → `DMA_RD_RESP_ERR`.
  - `rlast_i` = 1 before the expected last beat → `DMA_RLAST_ERR`. The burst is not ended early.
  - `rlast_i` = 0 on the expected last beat → `DMA_RLAST_ERR`. The burst ends anyway: pop tracker, clear `beat_cnt`.
  - Data still flows after an error.
  - `err_clr_i` zeroes `rd_err_o`. If a new error occurs in the same cycle as `err_clr_i`, the new error is captured.
- Reset (any time): queue, tracker, AR slot, `beat_cnt` and error all cleared. In-flight bursts are abandoned.

## Timing
- Reset values: all outputs 0, except `dma_axi_resp_o.ready`=1 and `idle_o`=1.
- Latency:
  - Request handshake in cycle N → `arvalid_o` earliest in N+2 (no queue bypass).
  - R beat → `rd_*` same cycle (0 latency).
- Throughput: with `arready_i` held high and the tracker not full, one AR per cycle is sustained.
- Simultaneous push and pop on a full queue: not possible, since `ready`=0 when full.
- Simultaneous push and pop on a non-full queue: both occur; count unchanged.
- Tracker full: the AR slot does not reload. R pops free space; reload happens in the next cycle.
- Pointers wrap modulo depth; full/empty are resolved with an extra pointer MSB.
- `idle_o` is combinational from the registered state.

## Structure
- `dma_pkg` gains:
  - the `DMA_RD_RESP_ERR` and `DMA_RLAST_ERR` error sources;
  - `s_dma_rd_trk_t` `{addr, alen, strb}`;
  - `s_dma_rd_req_ent_t` `{addr, alen, size, strb}`;
  - the localparam `DMA_AXI_BURST_INCR`.
- One sub-module, `dma_sync_fifo`, parameterized by type and depth, with `full`/`empty` outputs. It is instantiated twice: request queue and tracker.

## Test plan
- Single request `addr=0x1000, alen=3`, `arready_i`=1, 4 R beats, last with `rlast`. Required:
  - `arvalid_o` at N+2 with `araddr_o=0x1000, arlen_o=3, arburst_o=1`;
  - 4 `rd_valid_o` beats, `rd_strb_o='1`, `rd_last_o` on beat 4;
  - `idle_o`=1 afterwards.
- Narrow request `addr=0x2040, alen=0, strb=0x0000_00FF_0000_0000`. Required: one beat with `rd_strb_o` equal to that strobe, and `rd_last_o`=1.
- Six `alen=0` requests with `arready_i`=0. Required:
  - `dma_axi_resp_o.ready` drops after the 4 queued plus 1 in the AR slot (queue full);
  - raising `arready_i` issues 4 ARs; the 5th is held until one R burst completes (`MAX_OUTSTANDING`=4).
- `alen=1` burst with `rlast_i`=1 on beat 1. Required: `rd_err_o={valid=1, src=DMA_RLAST_ERR, addr=burst addr}`; the burst still ends after beat 2.
- `rresp_i=2'b10` on beat 0, then `err_clr_i` pulse. Required: `DMA_RD_RESP_ERR` is held until the clear, then `rd_err_o`=0.
- `rstn` low mid-burst with 2 outstanding. Required: all outputs reach their reset values immediately (asynchronously), and `idle_o`=1 after release.
